// File: rtl/clk_en_gen.sv
// Clock-enable generator: NUM_CH programmable single-cycle strobes on one clock, gated by PLL-lock qualification.
// Latency: strobe registered one cycle after counter wrap; divisor writes land at the next wrap (or next cycle when idle).
// Backpressure: none; writes are always accepted, strobes free-run. Optional macro CLKEN_TICK_CNT_EN adds per-channel strobe counters.
module clk_en_gen #(
    parameter int                         NUM_CH   = 4,
    parameter int                         CNT_W    = 8,
    parameter logic [NUM_CH*CNT_W-1:0]    DIV_INIT = 32'h08040201,
    parameter int                         LOCK_DLY = 1024,
    localparam int                        CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          locked_i,
    input  logic                          sync_i,
    input  logic                          wr_en,
    input  logic [CH_W-1:0]               wr_ch,
    input  logic [CNT_W-1:0]              wr_div,
    output logic [NUM_CH-1:0]             ce_o,
    output logic                          running_o,
    output logic [NUM_CH*CNT_W-1:0]       cur_div_o
`ifdef CLKEN_TICK_CNT_EN
    ,
    output logic [NUM_CH*16-1:0]          tick_cnt_o
`endif
);

    typedef enum logic [1:0] {S_HOLD, S_QUAL, S_RUN} state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [15:0]      LOCK_END = 16'(LOCK_DLY - 1);

    state_t             r_state;
    logic               r_running;
    logic [15:0]        r_lock_cnt;
    logic [NUM_CH-1:0]  r_ce;
    logic [CNT_W-1:0]   r_cnt      [NUM_CH];
    logic [CNT_W-1:0]   r_act_div  [NUM_CH];
    logic [CNT_W-1:0]   r_pend_div [NUM_CH];
    logic [NUM_CH-1:0]  r_pend;

    logic               w_run;
    logic               w_lock_loss;
    logic               w_sync;
    logic [NUM_CH-1:0]  w_wr_hit;

    assign w_run       = (r_state == S_RUN);
    assign w_lock_loss = w_run && !locked_i;
    assign w_sync      = w_run && locked_i && sync_i;

    // Decode the write strobe per channel; an out-of-range channel matches nothing.
    always_comb begin
        w_wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr_hit[i] = wr_en && (32'(wr_ch) == $unsigned(i));
        end
    end

    // Lock qualification FSM: LOCK_DLY consecutive locked cycles in QUAL before RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_HOLD;
            r_running  <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_lock_cnt <= '0;
                    if (locked_i) r_state <= S_QUAL;
                end
                S_QUAL: begin
                    if (!locked_i) begin
                        r_state    <= S_HOLD;
                        r_lock_cnt <= '0;
                    end else if (r_lock_cnt == LOCK_END) begin
                        r_state    <= S_RUN;
                        r_running  <= 1'b1;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 16'd1;
                    end
                end
                S_RUN: begin
                    if (!locked_i) begin
                        r_state    <= S_HOLD;
                        r_running  <= 1'b0;
                        r_lock_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= S_HOLD;
                    r_running  <= 1'b0;
                    r_lock_cnt <= '0;
                end
            endcase
        end
    end

    // Per-channel divide counters, strobes and pending-divisor handoff.
    // The write capture comes last so a same-cycle write survives an apply of the older pending value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ce   <= '0;
            r_pend <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]      <= '0;
                r_act_div[i]  <= DIV_INIT[i*CNT_W +: CNT_W];
                r_pend_div[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_lock_loss) begin
                    r_cnt[i] <= '0;
                    r_ce[i]  <= 1'b0;
                end else if (w_sync || !w_run || (r_act_div[i] == '0)) begin
                    r_cnt[i] <= '0;
                    r_ce[i]  <= 1'b0;
                    if (r_pend[i]) begin
                        r_act_div[i] <= r_pend_div[i];
                        r_pend[i]    <= 1'b0;
                    end
                end else if (r_cnt[i] == (r_act_div[i] - ONE)) begin
                    r_cnt[i] <= '0;
                    r_ce[i]  <= 1'b1;
                    if (r_pend[i]) begin
                        r_act_div[i] <= r_pend_div[i];
                        r_pend[i]    <= 1'b0;
                    end
                end else begin
                    r_cnt[i] <= r_cnt[i] + ONE;
                    r_ce[i]  <= 1'b0;
                end
                if (w_wr_hit[i]) begin
                    r_pend_div[i] <= wr_div;
                    r_pend[i]     <= 1'b1;
                end
            end
        end
    end

    // Expose only the active divisors, packed like DIV_INIT.
    always_comb begin
        cur_div_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cur_div_o[i*CNT_W +: CNT_W] = r_act_div[i];
        end
    end

    assign ce_o      = r_ce;
    assign running_o = r_running;

`ifdef CLKEN_TICK_CNT_EN
    logic [15:0] r_tick [NUM_CH];

    // Count registered strobes per channel; cleared on re-phase and on leaving RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) r_tick[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_lock_loss || w_sync) r_tick[i] <= '0;
                else                       r_tick[i] <= r_tick[i] + {15'd0, r_ce[i]};
            end
        end
    end

    // Pack the strobe counters for the output port.
    always_comb begin
        tick_cnt_o = '0;
        for (int i = 0; i < NUM_CH; i++) tick_cnt_o[i*16 +: 16] = r_tick[i];
    end
`endif

endmodule
